// File: rtl/wb_pkg.sv
// Shared widths, the queued write-back entry type and a register-index decoder.
package wb_pkg;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned RF_SEL_W  = 6;
    localparam int unsigned NUM_REGS  = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] dst_decode(input logic [REG_IDX_W-1:0] dst);
        return NUM_REGS'(1) << dst;
    endfunction
endpackage

// File: rtl/reg_writeback_ctrl_fifo.sv
// Write-back entry FIFO: two pushes (push0 older than push1) and one pop per cycle; entries in age order.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push0,
    input  wb_entry_t                entry0,
    input  logic                     push1,
    input  wb_entry_t                entry1,
    input  logic                     pop,
    output wb_entry_t [DEPTH-1:0]    ordered,
    output logic [DEPTH-1:0]         ordered_vld,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t          slots [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   push_n;

    assign push_n = CNT_W'(push0) + CNT_W'(push1);
    assign count  = count_q;

    // Storage; a push into the slot being popped this cycle is safe since the head is read before the edge.
    always_ff @(posedge clk) begin
        if (!flush && push0) slots[wr_ptr] <= entry0;
        if (!flush && push1) slots[wr_ptr + PTR_W'(1)] <= entry1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr + PTR_W'(pop);
            wr_ptr  <= wr_ptr + PTR_W'(push_n);
            count_q <= count_q + push_n - CNT_W'(pop);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            ordered[k]     = slots[rd_ptr + PTR_W'(k)];
            ordered_vld[k] = (CNT_W'(k) < count_q);
        end
    end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-bank write-back initiator: buffers ALU/load results, issues one bank write per cycle, yields to reads.
// Optional WB_BYPASS_EN adds two combinational forwarding lookup ports.
module reg_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [REG_IDX_W-1:0]    alu_dst,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [REG_IDX_W-1:0]    mem_dst,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic                    rd_req,
    input  logic                    flush,
    output logic [RF_SEL_W-1:0]     rf_sel,
    output logic [DATA_W-1:0]       rf_data,
    output logic                    rf_we,
    output logic [NUM_REGS-1:0]     busy_mask,
`ifdef WB_BYPASS_EN
    input  logic [REG_IDX_W-1:0]    byp_sel_a,
    input  logic [REG_IDX_W-1:0]    byp_sel_b,
    output logic                    byp_hit_a,
    output logic                    byp_hit_b,
    output logic [DATA_W-1:0]       byp_data_a,
    output logic [DATA_W-1:0]       byp_data_b,
`endif
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX);

    wb_entry_t [DEPTH-1:0]   ordered;
    logic [DEPTH-1:0]        ordered_vld;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        free;
    logic [STV_W-1:0]        starve_cnt;
    logic [REG_IDX_W-1:0]    rf_dst;
    logic                    force_wr;
    logic                    pop;
    logic                    full;
    logic                    mem_push;
    logic                    alu_push;
    logic                    push0;
    logic                    push1;
    wb_entry_t               entry0;
    wb_entry_t               alu_entry;
    wb_entry_t               mem_entry;

    assign full       = (count == CNT_W'(DEPTH));
    assign force_wr   = (starve_cnt == STV_W'(STARVE_MAX - 1));
    assign pop        = ordered_vld[0] & ~flush & (~rd_req | force_wr);
    // A pop in this cycle already counts as free space.
    assign free       = CNT_W'(DEPTH) - count + CNT_W'(pop);

    assign mem_ready  = rst_n & ~flush & (free >= CNT_W'(1));
    assign alu_ready  = rst_n & ~flush & ((free >= CNT_W'(2)) | ((free == CNT_W'(1)) & ~mem_valid));

    assign mem_entry  = '{dst: mem_dst, data: mem_data};
    assign alu_entry  = '{dst: alu_dst, data: alu_data};
    assign mem_push   = mem_valid & mem_ready & (mem_dst != '0);
    assign alu_push   = alu_valid & alu_ready & (alu_dst != '0);

    // The load is the older instruction, so it takes the first slot when both arrive together.
    assign push0      = mem_push | alu_push;
    assign push1      = mem_push & alu_push;
    assign entry0     = mem_push ? mem_entry : alu_entry;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .push0       (push0),
        .entry0      (entry0),
        .push1       (push1),
        .entry1      (alu_entry),
        .pop         (pop),
        .ordered     (ordered),
        .ordered_vld (ordered_vld),
        .count       (count)
    );

    assign fifo_count = count;
    assign rf_sel     = RF_SEL_W'(rf_dst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_dst  <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= pop;
            if (pop) begin
                rf_dst  <= ordered[0].dst;
                rf_data <= ordered[0].data;
            end
        end
    end

    // Counts consecutive cycles where a full queue is held off by readers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (flush || pop) begin
            starve_cnt <= '0;
        end else if (full && rd_req) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (ordered_vld[k]) busy_mask = busy_mask | dst_decode(ordered[k].dst);
        end
        if (rf_we) busy_mask = busy_mask | dst_decode(rf_dst);
        busy_mask[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    // Returns {hit, data}; later queue entries are younger and override the in-flight write.
    function automatic logic [DATA_W:0] byp_lookup(
        input logic [REG_IDX_W-1:0] sel,
        input wb_entry_t [DEPTH-1:0] ents,
        input logic [DEPTH-1:0]      vld,
        input logic                  we,
        input logic [REG_IDX_W-1:0]  wdst,
        input logic [DATA_W-1:0]     wdata
    );
        logic              hit;
        logic [DATA_W-1:0] val;
        hit = 1'b0;
        val = '0;
        if (we && wdst == sel) begin
            hit = 1'b1;
            val = wdata;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (vld[k] && ents[k].dst == sel) begin
                hit = 1'b1;
                val = ents[k].data;
            end
        end
        if (sel == '0) begin
            hit = 1'b0;
            val = '0;
        end
        return {hit, val};
    endfunction

    always_comb begin
        {byp_hit_a, byp_data_a} = byp_lookup(byp_sel_a, ordered, ordered_vld, rf_we, rf_dst, rf_data);
        {byp_hit_b, byp_data_b} = byp_lookup(byp_sel_b, ordered, ordered_vld, rf_we, rf_dst, rf_data);
    end
`endif
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: queue-based reference model checked every cycle plus directed literal checks.
module tb_reg_writeback_ctrl;
    import wb_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, mem_valid, rd_req, flush;
    logic        alu_ready, mem_ready, rf_we;
    logic [4:0]  alu_dst, mem_dst;
    logic [31:0] alu_data, mem_data, rf_data, busy_mask;
    logic [5:0]  rf_sel;
    logic [2:0]  fifo_count;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_sel_a, byp_sel_b;
    logic        byp_hit_a, byp_hit_b;
    logic [31:0] byp_data_a, byp_data_b;
`endif

    reg_writeback_ctrl #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_dst    (alu_dst),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_dst    (mem_dst),
        .mem_data   (mem_data),
        .rd_req     (rd_req),
        .flush      (flush),
        .rf_sel     (rf_sel),
        .rf_data    (rf_data),
        .rf_we      (rf_we),
        .busy_mask  (busy_mask),
`ifdef WB_BYPASS_EN
        .byp_sel_a  (byp_sel_a),
        .byp_sel_b  (byp_sel_b),
        .byp_hit_a  (byp_hit_a),
        .byp_hit_b  (byp_hit_b),
        .byp_data_a (byp_data_a),
        .byp_data_b (byp_data_b),
`endif
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a plain queue in acceptance order.
    wb_entry_t   mq[$];
    logic        m_we    = 1'b0;
    logic [4:0]  m_dst   = '0;
    logic [31:0] m_data  = '0;
    int          m_starve = 0;
    bit          s_pop, s_mr, s_ar, s_full;
    logic [31:0] exp_busy;

    function automatic bit m_pop();
        return rst_n && mq.size() > 0 && !flush && (!rd_req || m_starve == STARVE_MAX - 1);
    endfunction
    function automatic int m_free();
        return DEPTH - mq.size() + (m_pop() ? 1 : 0);
    endfunction
    function automatic bit m_mem_rdy();
        return rst_n && !flush && m_free() >= 1;
    endfunction
    function automatic bit m_alu_rdy();
        return rst_n && !flush && (m_free() >= 2 || (m_free() == 1 && !mem_valid));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_we = 1'b0; m_dst = '0; m_data = '0; m_starve = 0;
        end else begin
            s_pop  = m_pop();
            s_mr   = m_mem_rdy();
            s_ar   = m_alu_rdy();
            s_full = (mq.size() == DEPTH);
            if (flush) begin
                mq.delete();
                m_starve = 0;
                m_we = 1'b0;
            end else begin
                if (s_pop) begin
                    m_we = 1'b1; m_dst = mq[0].dst; m_data = mq[0].data;
                    void'(mq.pop_front());
                    m_starve = 0;
                end else begin
                    m_we = 1'b0;
                    if (s_full && rd_req) m_starve++;
                end
                if (mem_valid && s_mr && mem_dst != 0) mq.push_back('{dst: mem_dst, data: mem_data});
                if (alu_valid && s_ar && alu_dst != 0) mq.push_back('{dst: alu_dst, data: alu_data});
            end
        end
    end

`ifdef WB_BYPASS_EN
    function automatic logic [32:0] m_byp(input logic [4:0] sel);
        if (sel == 0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].dst == sel) return {1'b1, mq[i].data};
        if (m_we && m_dst == sel) return {1'b1, m_data};
        return '0;
    endfunction
`endif

    always @(negedge clk) begin
        exp_busy = '0;
        foreach (mq[i]) exp_busy[mq[i].dst] = 1'b1;
        if (m_we) exp_busy[m_dst] = 1'b1;
        exp_busy[0] = 1'b0;
        chk("alu_ready",  alu_ready,  m_alu_rdy());
        chk("mem_ready",  mem_ready,  m_mem_rdy());
        chk("rf_we",      rf_we,      m_we);
        chk("rf_sel",     rf_sel,     {1'b0, m_dst});
        chk("rf_data",    rf_data,    m_data);
        chk("busy_mask",  busy_mask,  exp_busy);
        chk("fifo_count", fifo_count, mq.size());
`ifdef WB_BYPASS_EN
        chk("byp_a", {byp_hit_a, byp_data_a}, m_byp(byp_sel_a));
        chk("byp_b", {byp_hit_b, byp_data_b}, m_byp(byp_sel_b));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        alu_valid = 0; mem_valid = 0; flush = 0;
        alu_dst = 0; mem_dst = 0; alu_data = 0; mem_data = 0;
    endtask

    task automatic offer_alu(input logic [4:0] d, input logic [31:0] v);
        alu_valid = 1; alu_dst = d; alu_data = v;
    endtask

    task automatic offer_mem(input logic [4:0] d, input logic [31:0] v);
        mem_valid = 1; mem_dst = d; mem_data = v;
    endtask

    task automatic drain(input int n);
        clr_in();
        rd_req = 0;
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 0; rd_req = 0;
        clr_in();
`ifdef WB_BYPASS_EN
        byp_sel_a = 0; byp_sel_b = 0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready", {alu_ready, mem_ready}, 2'b00);
        chk("rst_count", fifo_count, 0);
        rst_n = 1;
        tick();

        // Single ALU write: two-cycle latency, one-cycle pulse.
        offer_alu(8, 32'h1234);
        @(negedge clk); chk("t1_ready", alu_ready, 1);
        tick(); clr_in();
        @(negedge clk); chk("t1_we_n1", rf_we, 0); chk("t1_busy_n1", busy_mask[8], 1);
        tick();
        @(negedge clk); chk("t1_write", {rf_we, rf_sel, rf_data}, {1'b1, 6'd8, 32'h1234});
        chk("t1_busy_n2", busy_mask[8], 1);
        tick();
        @(negedge clk); chk("t1_we_n3", rf_we, 0); chk("t1_busy_n3", busy_mask, 0);
        tick();

        // Simultaneous load and ALU result to the same register: load lands first.
        offer_mem(9, 32'hAAAA0000); offer_alu(9, 32'h5555);
        @(negedge clk); chk("t2_ready", {mem_ready, alu_ready}, 2'b11);
        tick(); clr_in();
        @(negedge clk); chk("t2_count", fifo_count, 2);
        tick();
        @(negedge clk); chk("t2_first", {rf_we, rf_data}, {1'b1, 32'hAAAA0000});
        tick();
        @(negedge clk); chk("t2_second", {rf_we, rf_data}, {1'b1, 32'h5555});
        tick();
        @(negedge clk); chk("t2_done", rf_we, 0);
        tick();

        // Writes to register 0 are accepted and dropped.
        offer_alu(0, 32'hFFFFFFFF);
        @(negedge clk); chk("t3_ready", alu_ready, 1);
        tick(); clr_in();
        repeat (3) begin
            @(negedge clk); chk("t3_idle", {rf_we, busy_mask, fifo_count}, 36'h0);
            tick();
        end

        // Starvation guard: full queue held off by readers is forced after STARVE_MAX-1 cycles.
        rd_req = 1;
        offer_mem(1, 32'h101); offer_alu(2, 32'h202);
        tick();
        offer_mem(3, 32'h303); offer_alu(4, 32'h404);
        @(negedge clk); chk("t4_ready2", {mem_ready, alu_ready}, 2'b11);
        tick(); clr_in();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("t4_held", {rf_we, mem_ready, fifo_count}, {1'b0, 1'b0, 3'd4});
            tick();
        end
        @(negedge clk); chk("t4_force_cycle", {rf_we, mem_ready}, 2'b01);
        tick();
        @(negedge clk); chk("t4_forced", {rf_we, rf_sel, fifo_count}, {1'b1, 6'd1, 3'd3});
        tick();
        drain(5);

        // Full queue with simultaneous pop: one push fits, a second does not.
        rd_req = 1;
        offer_mem(14, 32'hE); offer_alu(15, 32'hF);
        tick();
        offer_mem(16, 32'h10); offer_alu(17, 32'h11);
        tick(); clr_in();
        rd_req = 0;
        offer_mem(18, 32'h12); offer_alu(19, 32'h13);
        @(negedge clk); chk("t7_full_pop", {mem_ready, alu_ready, fifo_count}, {2'b10, 3'd4});
        tick(); clr_in();
        @(negedge clk); chk("t7_after", {fifo_count, rf_sel}, {3'd4, 6'd14});
        tick();
        drain(6);

        // Flush with a write already in flight.
        rd_req = 1;
        offer_mem(10, 32'hA0); offer_alu(11, 32'hB0);
        tick(); clr_in();
        offer_alu(12, 32'hC0);
        tick(); clr_in();
        rd_req = 0;
        @(negedge clk); chk("t5_count", fifo_count, 3);
        tick();
        rd_req = 1; flush = 1;
        offer_alu(13, 32'hD0);
        @(negedge clk);
        chk("t5_flush_ready", {alu_ready, mem_ready}, 2'b00);
        chk("t5_inflight", {rf_we, rf_sel, busy_mask[10]}, {1'b1, 6'd10, 1'b1});
        tick(); clr_in();
        @(negedge clk); chk("t5_after", {fifo_count, busy_mask, rf_we}, 36'h0);
        tick();
        rd_req = 0;
        tick();

`ifdef WB_BYPASS_EN
        rd_req = 1;
        offer_alu(5, 32'h11);
        tick();
        offer_alu(5, 32'h22);
        tick(); clr_in();
        byp_sel_a = 5; byp_sel_b = 0;
        @(negedge clk);
        chk("t6_hit_a", {byp_hit_a, byp_data_a}, {1'b1, 32'h22});
        chk("t6_hit_b", byp_hit_b, 0);
        tick();
        drain(3);
        byp_sel_a = 0;
`endif

        // Mixed traffic table checked by the model each cycle.
        for (int i = 0; i < 48; i++) begin
            mem_valid = (i % 3) != 1;
            mem_dst   = 5'(i * 7);
            mem_data  = 32'(i) * 32'h01010101;
            alu_valid = (i % 4) != 3;
            alu_dst   = 5'(i * 3 + 1);
            alu_data  = 32'hC0DE0000 + 32'(i);
            rd_req    = (i % 7) >= 4;
            flush     = (i == 30);
`ifdef WB_BYPASS_EN
            byp_sel_a = 5'(i * 3 + 1);
            byp_sel_b = 5'(i);
`endif
            tick();
        end
        drain(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
